seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed hex digits; legal values are even and 2..8.
REQ-002 SHALL have parameter DIV, default 50000, clk cycles per digit slot; minimum value is GUARD+2.
REQ-003 SHALL have parameter GUARD, default 1, anode-off cycles at the start of each digit slot (ghosting guard).
REQ-004 SHALL have port clk  input  1  clock; all logic is rising-edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  upstream byte valid (LFSR/producer stage).
REQ-007 SHALL have port in_data  input  8  byte to display (two hex digits).
REQ-008 SHALL have port in_ready  output  1  byte accepted on a clk edge when in_valid and in_ready are both 1.
REQ-009 SHALL have port blank  input  1  forces all digits off.
REQ-010 SHALL have port an  output  DIGITS  active-low digit enables; bit i selects digit i (digit 0 is rightmost).
REQ-011 SHALL have port seg  output  8  active-low segments; bit7..bit1 = a..g, bit0 = dp.

Function
REQ-012 SHALL hold a one-deep pending byte register; in_ready = !pend_full && !rst, combinational.
REQ-013 SHALL, on an accepted handshake, load in_data into pending and set pend_full on the next edge.
REQ-014 SHALL keep a display buffer of DIGITS*4 bits; nibble i drives digit i.
REQ-015 SHALL apply pending only at frame boundaries: the prescaler tick on which the digit index wraps from DIGITS-1 to 0.
REQ-016 SHALL, at a frame boundary with pend_full=1, update buf to {buf[DIGITS*4-9:0], pend} and clear pend_full in the same edge.
REQ-017 SHALL defer a handshake that coincides with a frame boundary, with pending previously empty, so that the byte commits at the next boundary.
REQ-018 SHALL hold in_ready at 0 while pending is full; in_data is not sampled during that time.
REQ-019 SHALL run a prescaler counting 0..DIV-1 with a one-cycle tick at DIV-1; the tick advances the digit index modulo DIGITS.
REQ-020 SHALL make the frame period DIGITS*DIV cycles, free-running and independent of handshakes.
REQ-021 SHALL drive all an bits high while prescaler < GUARD; otherwise an[idx]=0 and all other bits are 1.
REQ-022 SHALL drive seg as the inverse of the hex code of buf nibble idx; dp is always off (seg[0]=1).
REQ-023 SHALL use these active-high hex codes for 0..F: FC 60 DA F2 66 B6 BE E0 FE F6 EE 3E 9C 7A 9E 8E.
REQ-024 SHALL, when blank=1, drive an to all ones and seg to 8'hFF; scanning, handshakes and commits continue unaffected.
REQ-025 SHALL register an and seg, giving one cycle of latency from idx/prescaler/buf/blank to the pins.

Reset
REQ-026 SHALL, while rst=1 on an edge, set prescaler=0, idx=0, buf=0, pend=0, pend_full=0, an=all ones, seg=8'hFF.
REQ-027 SHALL, on rst asserted mid-frame, discard pending and buffer contents; the first frame after release starts at digit 0, prescaler 0.

Structure
REQ-028 SHALL place the 16-entry hex-to-segment code table and the segment bit-order constants in shared package seg_pkg.
REQ-029 SHALL instantiate one combinational sub-module, hex7seg (4-bit in, 8-bit active-high code out), using seg_pkg.

Verification (DIGITS=4, DIV=4, GUARD=1)
REQ-030 SHALL cover reset: rst=1 for 3 cycles -> an=4'hF, seg=8'hFF, in_ready=0; after release in_ready=1.
REQ-031 SHALL cover commit: send 0x5A, then 0x3C after the first commit -> buf=16'h5A3C; in the slot for digit 0, an=4'b1110, seg=8'h63.
REQ-032 SHALL cover backpressure: send 0x11 and 0x22 back-to-back -> in_ready=0 from the cycle after the first accept until the boundary; 0x22 is held and accepted after the commit.
REQ-033 SHALL cover the guard: at each slot change an=4'hF for exactly 1 cycle, then the one-hot-low pattern for 3 cycles.
REQ-034 SHALL cover blank: assert blank mid-slot -> an=4'hF and seg=8'hFF one cycle later; deasserting resumes the current idx.
REQ-035 SHALL cover reset mid-operation: rst with pend_full=1 at idx=2 -> after release buf=0, digit 0 is active first, and seg=8'h03 (code FC inverted).

Source files
------------

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
//   Shared constants for the seven-segment display path.
//   - Bit positions of each segment inside the 8-bit segment bus
//     (bit7..bit1 = a..g, bit0 = decimal point).
//   - 16-entry hex-to-segment code table, active-high (1 = segment lit).
//   - All-off pattern for the active-low pins.
// -----------------------------------------------------------------------------
package seg_pkg;

    // Segment bit order on the 8-bit bus.
    localparam int SEG_A_BIT  = 7;
    localparam int SEG_B_BIT  = 6;
    localparam int SEG_C_BIT  = 5;
    localparam int SEG_D_BIT  = 4;
    localparam int SEG_E_BIT  = 3;
    localparam int SEG_F_BIT  = 2;
    localparam int SEG_G_BIT  = 1;
    localparam int SEG_DP_BIT = 0;

    // Active-low pins: every bit high means every segment dark.
    localparam logic [7:0] SEG_ALL_OFF = 8'hFF;

    // Active-high codes for hex digits 0..F. The dp bit is always 0 here.
    localparam logic [7:0] HEX7SEG_TABLE [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2,
        8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E,
        8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

endpackage : seg_pkg

// File: rtl/seg_scan_driver_hex7seg.sv
// -----------------------------------------------------------------------------
// hex7seg
//   Purely combinational hex nibble to seven-segment code converter.
//   Ports:
//     hex  in   4  hex digit value 0..F
//     code out  8  active-high segment code, bit7..bit1 = a..g, bit0 = dp
//   The decimal point is never lit by this converter.
// -----------------------------------------------------------------------------
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [7:0] code
);

    always_comb begin
        // NOTE: every output of an always_comb block gets a value on every
        // path (here by a default first), otherwise a latch is inferred.
        code             = HEX7SEG_TABLE[hex];
        code[SEG_DP_BIT] = 1'b0;
    end

endmodule : hex7seg

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//   Time-multiplexed hex display driver fed by a valid/ready byte stream.
//
//   Each accepted byte is parked in a one-deep pending register and is only
//   shifted into the display buffer at a frame boundary, so a frame is never
//   torn between two buffer contents. The scan itself is free-running: a
//   prescaler divides clk into digit slots, and each slot begins with GUARD
//   cycles of all anodes off to avoid ghosting between adjacent digits.
//
//   Parameters:
//     DIGITS  number of digits, even, 2..8
//     DIV     clk cycles per digit slot, at least GUARD+2
//     GUARD   anode-off cycles at the start of each slot
//
//   Ports:
//     clk       in   1        rising-edge clock
//     rst       in   1        synchronous, active-high reset
//     in_valid  in   1        upstream byte valid
//     in_data   in   8        byte to display (two hex digits)
//     in_ready  out  1        byte taken on an edge with in_valid && in_ready
//     blank     in   1        forces all digits off, scan keeps running
//     an        out  DIGITS   active-low digit enables, bit 0 = rightmost
//     seg       out  8        active-low segments, bit7..bit1 = a..g, bit0 = dp
// -----------------------------------------------------------------------------
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int GUARD  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              blank,
    output logic [DIGITS-1:0] an,
    output logic [7:0]        seg
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam int BW = DIGITS * 4;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PRESC_GRD  = PW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PW-1:0]     presc_q,     presc_d;
    logic [IW-1:0]     idx_q,       idx_d;
    logic [BW-1:0]     disp_q,      disp_d;
    logic [7:0]        pend_q,      pend_d;
    logic              pend_full_q, pend_full_d;
    logic [DIGITS-1:0] an_q,        an_d;
    logic [7:0]        seg_q,       seg_d;

    // -------------------------------------------------------------------------
    // Derived controls
    // -------------------------------------------------------------------------
    logic       presc_tick;
    logic       frame_end;
    logic       accept;
    logic [3:0] cur_nibble;
    logic [7:0] cur_code;
    logic [BW-1:0] disp_shift;

    assign in_ready   = !pend_full_q && !rst;
    assign accept     = in_valid && in_ready;
    assign presc_tick = (presc_q == PRESC_LAST);
    // The tick that wraps the digit index back to 0 closes the frame.
    assign frame_end  = presc_tick && (idx_q == IDX_LAST);
    assign cur_nibble = disp_q[{idx_q, 2'b00} +: 4];

    // New byte enters at the right (digits 0/1); older bytes move left and the
    // oldest byte falls off. With only two digits the byte simply replaces
    // the buffer, and the slice below would be empty.
    if (BW > 8) begin : g_shift
        assign disp_shift = {disp_q[BW-9:0], pend_q};
    end else begin : g_load
        assign disp_shift = pend_q;
    end

    hex7seg u_hex7seg (
        .hex  (cur_nibble),
        .code (cur_code)
    );

    // -------------------------------------------------------------------------
    // Scan timing: prescaler and digit index
    // -------------------------------------------------------------------------
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_tick) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Pending byte and display buffer
    // -------------------------------------------------------------------------
    always_comb begin
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        disp_d      = disp_q;

        if (frame_end && pend_full_q) begin
            disp_d      = disp_shift;
            pend_full_d = 1'b0;
        end

        // accept needs pend_full_q == 0, so it never overlaps the commit
        // above. A byte accepted on a boundary edge therefore waits one
        // whole frame before it is shown.
        if (accept) begin
            pend_d      = in_data;
            pend_full_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Pin drive (registered below)
    // -------------------------------------------------------------------------
    always_comb begin
        an_d             = '1;
        seg_d            = ~cur_code;
        seg_d[SEG_DP_BIT] = 1'b1;

        if (blank) begin
            seg_d = SEG_ALL_OFF;
        end else if (presc_q >= PRESC_GRD) begin
            an_d[idx_q] = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: the display buffer is an ordinary register here, not a RAM, so it
    // is cleared by reset along with everything else; a frame after reset
    // must show zeros rather than stale digits.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            presc_q     <= '0;
            idx_q       <= '0;
            disp_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            an_q        <= '1;
            seg_q       <= SEG_ALL_OFF;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule : seg_scan_driver

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//   Directed bench for seg_scan_driver with DIGITS=4, DIV=4, GUARD=1
//   (frame = 16 cycles, one guard cycle per 4-cycle slot).
//   cyc counts clock edges since reset release; outputs are sampled on the
//   falling edge, where the pins reflect the state one edge earlier.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       blank;
    logic [3:0] an;
    logic [7:0] seg;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    seg_scan_driver #(
        .DIGITS (4),
        .DIV    (4),
        .GUARD  (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .blank    (blank),
        .an       (an),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_seg [4];
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting (cyc %0d)", name, cyc);
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        while (cyc != target && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (cyc != target) timeout("wait_cyc");
    endtask

    task automatic wait_mod(input int m);
        int n = 0;
        while ((cyc % 16) != m && n < 40) begin
            @(negedge clk);
            n++;
        end
        if ((cyc % 16) != m) timeout("wait_mod");
    endtask

    // Present a byte at a falling edge, hold until accepted, then drop valid.
    task automatic send(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) timeout("send");
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait for pending to drain (in_ready back to 1); that is the commit edge.
    task automatic wait_commit(output int base);
        int n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) timeout("wait_commit");
        base = cyc;
        check("commit_on_frame_boundary", cyc % 16, 0);
    endtask

    // Inspect the middle of each digit slot of the frame starting at base.
    task automatic check_digits(input string name, input int base,
                                input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        logic [3:0] an_exp [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        an_exp[0] = 4'b1110; an_exp[1] = 4'b1101;
        an_exp[2] = 4'b1011; an_exp[3] = 4'b0111;
        for (int d = 0; d < 4; d++) begin
            wait_cyc(base + 4 * d + 3);
            check({name, "_an"},  {28'd0, an}, {28'd0, an_exp[d]});
            check({name, "_seg"}, {24'd0, seg}, {24'd0, e[d]});
        end
    endtask

    initial begin
        int base;
        int cnt;
        logic [3:0] an_exp;

        // Inverted codes: 0=03 1=9F 2=25 3=0D 4=99 5=49 6=41 7=1F
        //                 8=01 9=09 A=11 B=C1 C=63 D=85 E=61 F=71
        vecs[0] = '{8'h10, '{8'h03, 8'h9F, 8'h63, 8'h0D}};
        vecs[1] = '{8'h32, '{8'h25, 8'h0D, 8'h03, 8'h9F}};
        vecs[2] = '{8'h54, '{8'h99, 8'h49, 8'h25, 8'h0D}};
        vecs[3] = '{8'h76, '{8'h41, 8'h1F, 8'h99, 8'h49}};
        vecs[4] = '{8'h98, '{8'h01, 8'h09, 8'h41, 8'h1F}};
        vecs[5] = '{8'hBA, '{8'h11, 8'hC1, 8'h01, 8'h09}};
        vecs[6] = '{8'hDC, '{8'h63, 8'h85, 8'h11, 8'hC1}};
        vecs[7] = '{8'hFE, '{8'h61, 8'h71, 8'h63, 8'h85}};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        blank    = 1'b0;

        // ---- reset: three cycles held ----
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_an",       {28'd0, an},  32'h0000000F);
            check("rst_seg",      {24'd0, seg}, 32'h000000FF);
            check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        end
        rst = 1'b0;
        #1;
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        check("first_guard_an", {28'd0, an}, 32'h0000000F);

        // ---- commit: 0x5A then 0x3C -> buffer 5A3C ----
        send(8'h5A);
        wait_commit(base);
        check_digits("commit1", base, 8'h11, 8'h49, 8'h03, 8'h03);
        send(8'h3C);
        wait_commit(base);
        check_digits("commit2", base, 8'h63, 8'h0D, 8'h11, 8'h49);

        // ---- table: every hex code, with the previous byte shifted left ----
        for (int v = 0; v < 8; v++) begin
            send(vecs[v].data);
            wait_commit(base);
            check_digits($sformatf("vec%0d", v), base, vecs[v].exp_seg[0],
                         vecs[v].exp_seg[1], vecs[v].exp_seg[2], vecs[v].exp_seg[3]);
        end

        // ---- backpressure: 0x11 then 0x22 back-to-back ----
        wait_mod(5);
        check("bp_ready_before", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = 8'h11;
        @(posedge clk);
        @(negedge clk);
        in_data = 8'h22;
        cnt = 0;
        while (!in_ready && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check("bp_ready_low_cycles", cnt, 10);
        check("bp_release_at_boundary", cyc % 16, 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_second_accepted", {31'd0, in_ready}, 32'd0);
        wait_commit(base);
        check_digits("bp", base, 8'h25, 8'h25, 8'h9F, 8'h9F);

        // ---- handshake on the boundary edge is deferred one frame ----
        wait_mod(15);
        check("defer_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = 8'h77;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        base = cyc;
        check("defer_pending_full", {31'd0, in_ready}, 32'd0);
        wait_cyc(base + 3);
        check("defer_old_digit0", {24'd0, seg}, 32'h00000025);
        wait_commit(base);
        check_digits("defer", base, 8'h1F, 8'h1F, 8'h25, 8'h25);

        // ---- blank mid-slot (digit 1) ----
        wait_mod(6);
        check("pre_blank_an", {28'd0, an}, 32'h0000000D);
        blank = 1'b1;
        @(negedge clk);
        check("blank_an",    {28'd0, an},  32'h0000000F);
        check("blank_seg",   {24'd0, seg}, 32'h000000FF);
        check("blank_ready", {31'd0, in_ready}, 32'd1);
        blank = 1'b0;
        @(negedge clk);
        check("unblank_an",  {28'd0, an},  32'h0000000D);
        check("unblank_seg", {24'd0, seg}, 32'h0000001F);
        @(negedge clk);
        check("unblank_guard_an", {28'd0, an}, 32'h0000000F);
        @(negedge clk);
        check("unblank_next_an",  {28'd0, an},  32'h0000000B);
        check("unblank_next_seg", {24'd0, seg}, 32'h00000025);

        // ---- guard: one dark cycle at every slot start, one-hot otherwise ----
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (((cyc - 1) % 4) == 0) an_exp = 4'hF;
            else                      an_exp = ~(4'b0001 << (((cyc - 1) / 4) % 4));
            check("guard_an", {28'd0, an}, {28'd0, an_exp});
        end

        // ---- reset mid-operation with a byte pending at digit 2 ----
        wait_mod(8);
        in_valid = 1'b1;
        in_data  = 8'h99;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("midrst_pending_full", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_an",    {28'd0, an},  32'h0000000F);
        check("midrst_seg",   {24'd0, seg}, 32'h000000FF);
        check("midrst_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_guard", {28'd0, an}, 32'h0000000F);
        @(negedge clk);
        check("post_rst_an0",  {28'd0, an},  32'h0000000E);
        check("post_rst_seg0", {24'd0, seg}, 32'h00000003);
        wait_cyc(6);
        check("post_rst_an1",  {28'd0, an},  32'h0000000D);
        check("post_rst_seg1", {24'd0, seg}, 32'h00000003);
        wait_cyc(19);
        check("post_rst_no_commit_an",  {28'd0, an},  32'h0000000E);
        check("post_rst_no_commit_seg", {24'd0, seg}, 32'h00000003);
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute backstop so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cyc %0d)", cyc);
        $fatal(1, "global timeout");
    end

endmodule : tb_seg_scan_driver
